// File: rtl/dm_sb_responder_if.sv
// ============================================================================
// Module   : dm_sb_responder_if
// Brief    : Request/grant/response bus between a system-bus master and the
//            dm_sb_responder memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dm_sb_responder_if #(
    parameter int BusWidth = 32
);
    logic                    slave_req_i;
    logic [BusWidth-1:0]     slave_add_i;
    logic                    slave_we_i;
    logic [BusWidth-1:0]     slave_wdata_i;
    logic [BusWidth/8-1:0]   slave_be_i;
    logic                    slave_gnt_o;
    logic                    slave_r_valid_o;
    logic [BusWidth-1:0]     slave_r_rdata_o;
    logic                    slave_r_err_o;

    modport master (
        output slave_req_i, slave_add_i, slave_we_i, slave_wdata_i, slave_be_i,
        input  slave_gnt_o, slave_r_valid_o, slave_r_rdata_o, slave_r_err_o
    );

    modport slave (
        input  slave_req_i, slave_add_i, slave_we_i, slave_wdata_i, slave_be_i,
        output slave_gnt_o, slave_r_valid_o, slave_r_rdata_o, slave_r_err_o
    );
endinterface

`default_nettype wire

// File: rtl/dm_sb_responder.sv
// ============================================================================
// Module   : dm_sb_responder
// Brief    : System-bus slave memory model with programmable grant stall.
//            Optional macro DM_SB_RESPONDER_ERR_EN flags out-of-range words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_sb_responder #(
    parameter int BusWidth = 32,
    parameter int Depth    = 16
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    input  wire logic [2:0]  wait_cycles_i,
    dm_sb_responder_if.slave bus
);

    localparam int NB    = BusWidth / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(Depth);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]          r_state;
    logic [2:0]          r_cnt;
    logic [2:0]          r_n;
    logic                r_we;
    logic [IDX_W-1:0]    r_idx;
    logic                r_oor;
    logic [BusWidth-1:0] r_mem [Depth];

    logic                w_gnt;
    logic                w_wr;
    logic                w_resp;
    logic                w_oor;
    logic [IDX_W-1:0]    w_idx;

    assign w_idx = bus.slave_add_i[OFF_W +: IDX_W];

`ifdef DM_SB_RESPONDER_ERR_EN
    // Any address bit above the word index means the word lies beyond Depth.
    assign w_oor = |bus.slave_add_i[BusWidth-1:OFF_W+IDX_W];
`else
    assign w_oor = 1'b0;
`endif

    assign w_gnt = bus.slave_req_i &&
                   (((r_state == S_IDLE) && (wait_cycles_i == 3'd0)) ||
                    ((r_state == S_STALL) && (r_cnt == r_n)));
    assign w_wr  = w_gnt && bus.slave_we_i && !w_oor;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_n     <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.slave_req_i) begin
                        if (wait_cycles_i == 3'd0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_STALL;
                            r_cnt   <= 3'd1;
                            r_n     <= wait_cycles_i;
                        end
                    end
                end
                S_STALL: begin
                    if (!bus.slave_req_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 3'd0;
                    end else if (r_cnt == r_n) begin
                        r_state <= S_RESP;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Writes commit at the grant edge so the very next grant already sees them.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_we  <= 1'b0;
            r_idx <= '0;
            r_oor <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_gnt) begin
            r_we  <= bus.slave_we_i;
            r_idx <= w_idx;
            r_oor <= w_oor;
            if (w_wr) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.slave_be_i[b]) begin
                        r_mem[w_idx][b*8 +: 8] <= bus.slave_wdata_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign w_resp              = (r_state == S_RESP);
    assign bus.slave_gnt_o     = w_gnt;
    assign bus.slave_r_valid_o = w_resp;
    assign bus.slave_r_rdata_o = (w_resp && !r_we && !r_oor) ? r_mem[r_idx] : '0;

`ifdef DM_SB_RESPONDER_ERR_EN
    assign bus.slave_r_err_o = w_resp && r_oor;
`else
    assign bus.slave_r_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_sb_responder.sv
// ============================================================================
// Module   : tb_dm_sb_responder
// Brief    : Directed self-checking bench for dm_sb_responder (32-bit, 16 words).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_sb_responder;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [2:0] wait_cycles_i;
    int         checks   = 0;
    int         failures = 0;
    logic [34:0] e;

    dm_sb_responder_if #(.BusWidth(32)) bus ();

    dm_sb_responder #(.BusWidth(32), .Depth(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wait_cycles_i (wait_cycles_i),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;

    // {gnt, r_valid, r_err, rdata}
    function automatic logic [34:0] obs();
        return {bus.slave_gnt_o, bus.slave_r_valid_o, bus.slave_r_err_o, bus.slave_r_rdata_o};
    endfunction

    task automatic drive(input logic req, input logic we, input logic [31:0] add,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [2:0] wt);
        bus.slave_req_i   = req;
        bus.slave_we_i    = we;
        bus.slave_add_i   = add;
        bus.slave_wdata_i = wdata;
        bus.slave_be_i    = be;
        wait_cycles_i     = wt;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        step();
        step();
        @(negedge clk_i);
        e = 35'h0; checks++;
        if (obs() !== e) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs(), e); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 32'h8, 32'hA5A51234, 4'hF, 3'd0);
        @(negedge clk_i);
        e = {3'b100, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL wr_gnt got=%h exp=%h", obs(), e); end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL wr_resp got=%h exp=%h", obs(), e); end
        step();
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd0);
        @(negedge clk_i);
        e = {3'b100, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL rd_gnt got=%h exp=%h", obs(), e); end
        step();
        @(negedge clk_i);
        e = {3'b010, 32'hA5A51234}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL rd_resp got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_back_to_back();
        // request still held from the previous read: Idle grants again
        @(negedge clk_i);
        e = {3'b100, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL b2b_regnt got=%h exp=%h", obs(), e); end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'hA5A51234}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL b2b_resp got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 1'b1, 32'h8, 32'h0000FF00, 4'h2, 3'd0);
        @(negedge clk_i);
        e = {3'b100, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL be_wr_gnt got=%h exp=%h", obs(), e); end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        step();
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'hA5A5FF34}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL be_rd got=%h exp=%h", obs(), e); end
        step();
        // be=0 write still answers but changes nothing; low address bits ignored
        drive(1'b1, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL be0_resp got=%h exp=%h", obs(), e); end
        step();
        drive(1'b1, 1'b0, 32'hB, 32'h0, 4'hF, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'hA5A5FF34}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL be0_rd got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd3);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_i);
            e = 35'h0; checks++;
            if (obs() !== e) begin failures++; $display("FAIL stall_cyc%0d got=%h exp=%h", i, obs(), e); end
            step();
        end
        @(negedge clk_i);
        e = {3'b100, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL stall_gnt got=%h exp=%h", obs(), e); end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd3);
        @(negedge clk_i);
        e = {3'b010, 32'hA5A5FF34}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL stall_resp got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_stall_abort();
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd3);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            e = 35'h0; checks++;
            if (obs() !== e) begin failures++; $display("FAIL abort_quiet%0d got=%h exp=%h", i, obs(), e); end
            step();
        end
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd0);
        @(negedge clk_i);
        e = {3'b100, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL abort_regnt got=%h exp=%h", obs(), e); end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'hA5A5FF34}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL abort_resp got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b1, 32'h0, 32'h00000011, 4'hF, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        step();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 3'd0);
        @(negedge clk_i);
        e = {3'b100, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL oor_gnt got=%h exp=%h", obs(), e); end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
`ifdef DM_SB_RESPONDER_ERR_EN
        e = {3'b011, 32'h0};
`else
        e = {3'b010, 32'h00000011};
`endif
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL oor_rd got=%h exp=%h", obs(), e); end
        step();
        // write via an alias of word 1, then read word 1 directly
        drive(1'b1, 1'b1, 32'h44, 32'h00000077, 4'hF, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        step();
        drive(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
`ifdef DM_SB_RESPONDER_ERR_EN
        e = {3'b010, 32'h0};
`else
        e = {3'b010, 32'h00000077};
`endif
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL oor_wr_alias got=%h exp=%h", obs(), e); end
        step();
    endtask

    task automatic test_reset_in_resp();
        drive(1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL rr_resp got=%h exp=%h", obs(), e); end
        rst_ni = 1'b0;
        step();
        @(negedge clk_i);
        e = 35'h0; checks++;
        if (obs() !== e) begin failures++; $display("FAIL rr_dropped got=%h exp=%h", obs(), e); end
        rst_ni = 1'b1;
        step();
        drive(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
        @(negedge clk_i);
        e = {3'b010, 32'h0}; checks++;
        if (obs() !== e) begin failures++; $display("FAIL rr_mem_clear got=%h exp=%h", obs(), e); end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_byte_enable();
        test_stall();
        test_stall_abort();
        test_out_of_range();
        test_reset_in_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_sb_responder.md
DM_SB_RESPONDER -- requirements
Module: dm_sb_responder

Interface
REQ-001 SHALL have parameter BusWidth, default 32, bus data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter Depth, default 16, number of BusWidth-wide memory words; power of 2, at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port slave_req_i, input, 1 bit: request from the bus master.
REQ-006 SHALL have port slave_add_i, input, BusWidth bits: byte address.
REQ-007 SHALL have port slave_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port slave_wdata_i, input, BusWidth bits: write data.
REQ-009 SHALL have port slave_be_i, input, BusWidth/8 bits: byte enables.
REQ-010 SHALL have port slave_gnt_o, output, 1 bit: grant.
REQ-011 SHALL have port slave_r_valid_o, output, 1 bit: response valid, issued for reads and for writes.
REQ-012 SHALL have port slave_r_rdata_o, output, BusWidth bits: read data.
REQ-013 SHALL have port slave_r_err_o, output, 1 bit: response error (see Configuration).
REQ-014 SHALL have port wait_cycles_i, input, 3 bits: grant stall count, sampled while in Idle.

Function
REQ-015 SHALL implement states Idle, Stall and Resp.
REQ-016 Idle, slave_req_i=1, wait_cycles_i=0: SHALL assert slave_gnt_o combinationally in the same cycle, capture we/add/wdata/be, and go to Resp.
REQ-017 Idle, slave_req_i=1, wait_cycles_i=N>0: SHALL latch N, load stall counter to 1, go to Stall; gnt=0.
REQ-018 Stall, slave_req_i=1, counter<N: SHALL increment counter; gnt=0.
REQ-019 Stall, slave_req_i=1, counter==N: SHALL assert gnt, capture the transaction and go to Resp; gnt therefore appears in cycle N+1 of the held request.
REQ-020 Stall, slave_req_i=0: SHALL return to Idle, clear the counter, and issue no gnt and no response.
REQ-021 Resp: SHALL assert slave_r_valid_o for exactly one cycle, keep gnt=0 regardless of slave_req_i, then return to Idle; maximum throughput is one transaction per 2 cycles.
REQ-022 Word index SHALL be slave_add_i[log2(BusWidth/8) +: log2(Depth)]; the low address bits below it are ignored.
REQ-023 Writes SHALL update only the byte lanes whose slave_be_i bit is 1, at the clock edge ending the grant cycle; be=0 still produces a response.
REQ-024 In the Resp cycle, slave_r_rdata_o SHALL be the addressed word for reads and 0 for writes, and 0 whenever r_valid=0.
REQ-025 A read granted in the cycle after a write to the same word SHALL return the updated data.
REQ-026 gnt and r_valid SHALL never be high in the same cycle.

Reset
REQ-027 With rst_ni=0 at a clock edge, SHALL go to Idle and clear the counter, latched N, captured transaction and all memory words to 0.
REQ-028 From the cycle after reset, SHALL drive gnt=0, r_valid=0, rdata=0 and r_err=0; a pending Resp or Stall is discarded without a response.

Configuration
REQ-029 Macro DM_SB_RESPONDER_ERR_EN: when defined, an address with word offset >= Depth (out of range) SHALL give a normal grant and a response with r_err=1 and rdata=0, and an out-of-range write SHALL not modify memory.
REQ-030 When DM_SB_RESPONDER_ERR_EN is not defined, slave_r_err_o SHALL be tied to 0 and out-of-range addresses SHALL alias into memory through the index bits of REQ-022.

Verification (BusWidth=32, Depth=16)
REQ-031 wait=0, write 0xA5A51234 to address 0x8 with be=0xF -> gnt in the same cycle; r_valid next cycle with rdata=0; a following read of 0x8 returns 0xA5A51234.
REQ-032 After REQ-031, write wdata=0x0000FF00 to 0x8 with be=0x2 -> a read of 0x8 returns 0xA5A5FF34.
REQ-033 wait=3, request held -> gnt in the 4th request cycle; r_valid in the 5th cycle.
REQ-034 wait=3, request dropped after 1 cycle -> no gnt, no r_valid; state back to Idle; a new request with wait=0 is granted immediately.
REQ-035 Read of 0x40 after writing 0x11 to 0x0 -> with macro defined: r_err=1, rdata=0; without macro: rdata=0x11, r_err=0.
REQ-036 rst_ni=0 during the Resp cycle -> r_valid=0 from the next cycle; a read of 0x8 then returns 0.
